// File: rtl/adder_struct_pkg.sv
// Shared constants for the structural carry-lookahead adder.
// The operand width must stay a multiple of the lookahead group size.
package adder_struct_pkg;

   localparam int ADDER_WIDTH = 32;
   localparam int GRP_SIZE    = 4;

endpackage : adder_struct_pkg

// File: rtl/adder_struct_cla4_block.sv
// 4-bit carry-lookahead group: expands the in-group carries from bit-level
// propagate/generate and exports group propagate/generate for the
// second-level lookahead in the top.
module cla4_block
   import adder_struct_pkg::*;
(
   input  logic [GRP_SIZE-1:0] p_i,
   input  logic [GRP_SIZE-1:0] g_i,
   input  logic                c_i,
   output logic [GRP_SIZE-1:0] s_o,
   output logic                pg_o,
   output logic                gg_o
);

   logic [GRP_SIZE-1:0] c;

   // Flattened in-group carries: each carry is a sum of products, no chain.
   always_comb begin
      c[0] = c_i;
      c[1] = g_i[0] | (p_i[0] & c_i);
      c[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
      c[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
           | (p_i[2] & p_i[1] & p_i[0] & c_i);
   end

   assign s_o  = p_i ^ c;
   assign pg_o = &p_i;
   assign gg_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
               | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);

endmodule : cla4_block

// File: rtl/adder_struct.sv
// Two-level carry-lookahead adder: S = A + B + Cin, with per-bit propagate
// (A^B) and generate (A&B) exported for reuse as the ALU XOR/AND results.
// Compile-time option ADDER_OUT_REG_EN adds a one-cycle output register
// with asynchronous active-high reset; otherwise the block is combinational.
module adder_struct
   import adder_struct_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH
)(
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] P,
   output logic [WIDTH-1:0] G,
   output logic             Cout,
   output logic             OVF
);

   localparam int NGRP = WIDTH / GRP_SIZE;

   logic [WIDTH-1:0] p_w;
   logic [WIDTH-1:0] g_w;
   logic [WIDTH-1:0] s_d;
   logic [NGRP-1:0]  pg_w;
   logic [NGRP-1:0]  gg_w;
   logic [NGRP:0]    cg_w;
   logic             c_msb_w;
   logic             cout_d;
   logic             ovf_d;

   assign p_w = A ^ B;
   assign g_w = A & B;

   for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
      cla4_block u_grp (
         .p_i  (p_w[gi*GRP_SIZE +: GRP_SIZE]),
         .g_i  (g_w[gi*GRP_SIZE +: GRP_SIZE]),
         .c_i  (cg_w[gi]),
         .s_o  (s_d[gi*GRP_SIZE +: GRP_SIZE]),
         .pg_o (pg_w[gi]),
         .gg_o (gg_w[gi])
      );
   end

   // Second-level lookahead: each group carry is an OR of products of group
   // generate/propagate terms and Cin, so no group waits on its neighbour.
   always_comb begin : group_lookahead
      logic term;
      logic carry;
      term    = 1'b0;
      carry   = 1'b0;
      cg_w    = '0;
      cg_w[0] = Cin;
      for (int j = 1; j <= NGRP; j++) begin
         carry = 1'b0;
         for (int k = 0; k < j; k++) begin
            term = gg_w[k];
            for (int m = k + 1; m < j; m++) begin
               term = term & pg_w[m];
            end
            carry = carry | term;
         end
         term = Cin;
         for (int m = 0; m < j; m++) begin
            term = term & pg_w[m];
         end
         cg_w[j] = carry | term;
      end
   end

   // Since S = p ^ c bitwise, the carry into the MSB is recovered as S ^ p.
   assign c_msb_w = s_d[WIDTH-1] ^ p_w[WIDTH-1];
   assign cout_d  = cg_w[NGRP];
   assign ovf_d   = c_msb_w ^ cout_d;

`ifdef ADDER_OUT_REG_EN
   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] g_q;
   logic             cout_q;
   logic             ovf_q;

   // Output register: captures every cycle, async reset discards in-flight data.
   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together at the edge; the async reset sits in the sensitivity list.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         s_q    <= '0;
         p_q    <= '0;
         g_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         p_q    <= p_w;
         g_q    <= g_w;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign S    = s_q;
   assign P    = p_q;
   assign G    = g_q;
   assign Cout = cout_q;
   assign OVF  = ovf_q;
`else
   // Clock and reset have no function in the combinational build.
   logic unused_clock_reset;
   assign unused_clock_reset = CLOCK ^ RESET;

   assign S    = s_d;
   assign P    = p_w;
   assign G    = g_w;
   assign Cout = cout_d;
   assign OVF  = ovf_d;
`endif

endmodule : adder_struct

// File: tb/tb_adder_struct.sv
// Self-checking bench for adder_struct. Works with either build: when
// ADDER_OUT_REG_EN is defined it checks latency and reset behaviour of the
// output register, otherwise zero-latency combinational behaviour.
module tb_adder_struct;

   logic        CLOCK;
   logic        RESET;
   logic [31:0] A;
   logic [31:0] B;
   logic        Cin;
   logic [31:0] S;
   logic [31:0] P;
   logic [31:0] G;
   logic        Cout;
   logic        OVF;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] s;
      logic [31:0] p;
      logic [31:0] g;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vecs[11];

   adder_struct dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .S     (S),
      .P     (P),
      .G     (G),
      .Cout  (Cout),
      .OVF   (OVF)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Let the applied inputs reach the outputs: one edge in the registered
   // build, a short delay in the combinational build.
   task automatic settle();
`ifdef ADDER_OUT_REG_EN
      @(posedge CLOCK);
      #1;
`else
      #1;
`endif
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic [31:0] s, input logic [31:0] p, input logic [31:0] g,
                               input logic cout, input logic ovf);
      vec_t v;
      v.a = a; v.b = b; v.cin = cin;
      v.s = s; v.p = p; v.g = g; v.cout = cout; v.ovf = ovf;
      return v;
   endfunction

   initial begin
      logic [32:0] ref_sum;
      logic        ref_ovf;

      n_checks = 0;
      n_fail   = 0;

      //            A             B             Cin   S             P             G             Co    OVF
      vecs[0]  = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 32'h7FFFFFFE, 32'h00000001, 1'b0, 1'b1);
      vecs[1]  = mk(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
      vecs[2]  = mk(32'h00000005, 32'hFFFFFFFC, 1'b1, 32'h00000002, 32'hFFFFFFF9, 32'h00000004, 1'b1, 1'b0);
      vecs[3]  = mk(32'h00000003, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
      vecs[4]  = mk(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 1'b1);
      vecs[5]  = mk(32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hEFF1EFF0, 32'h0FF00FF0, 32'hF000F000, 1'b1, 1'b0);
      vecs[6]  = mk(32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
      vecs[7]  = mk(32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
      vecs[8]  = mk(32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 32'h0000000E, 32'h00000001, 1'b0, 1'b0);
      vecs[9]  = mk(32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 32'h0FFFFFFE, 32'h00000001, 1'b0, 1'b0);
      vecs[10] = mk(32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);

      RESET = 1'b1;
      A     = 32'h0;
      B     = 32'h0;
      Cin   = 1'b0;

`ifdef ADDER_OUT_REG_EN
      // Reset holds outputs at zero even with live operands and clock edges.
      A = 32'h1; B = 32'h1;
      @(posedge CLOCK); @(posedge CLOCK); #1;
      check("reset_hold", {S, P, G, Cout, OVF}, 98'h0);
      // Release between edges: still zero until the next posedge.
      RESET = 1'b0;
      #1;
      check("release_no_capture", {S, Cout, OVF}, 34'h0);
      @(posedge CLOCK); #1;
      check("first_capture_S", {S, Cout, OVF}, {32'h2, 1'b0, 1'b0});
      check("first_capture_PG", {P, G}, {32'h0, 32'h1});
      // New operand: old result visible until exactly one edge later.
      A = 32'h0000000F; B = 32'h00000001;
      #2;
      check("latency_old_S", S, 32'h2);
      @(posedge CLOCK); #1;
      check("latency_new_S", S, 32'h10);
      // Mid-stream reset between edges clears at once and drops the in-flight op.
      A = 32'h7; B = 32'h8;
      #2;
      RESET = 1'b1;
      #1;
      check("async_reset_clear", {S, P, G, Cout, OVF}, 98'h0);
      @(posedge CLOCK); #1;
      check("reset_discard", {S, Cout, OVF}, 34'h0);
      RESET = 1'b0;
      @(posedge CLOCK); #1;
      check("post_reset_capture", {S, P, G}, {32'hF, 32'hF, 32'h0});
`else
      // Combinational build: zero operands give all-zero outputs.
      #1;
      check("zero_inputs", {S, P, G, Cout, OVF}, 98'h0);
      RESET = 1'b0;
      // Zero latency, and RESET has no effect on the outputs.
      A = 32'h5; B = 32'hFFFFFFFC; Cin = 1'b1;
      #1;
      check("comb_zero_latency", {S, Cout, OVF}, {32'h2, 1'b1, 1'b0});
      RESET = 1'b1;
      #1;
      check("comb_reset_ignored", {S, Cout, OVF}, {32'h2, 1'b1, 1'b0});
      RESET = 1'b0;
      @(posedge CLOCK); #1;
`endif

      // Directed table.
      for (int i = 0; i < 11; i++) begin
         A   = vecs[i].a;
         B   = vecs[i].b;
         Cin = vecs[i].cin;
         settle();
         check($sformatf("vec%0d_S", i), S, vecs[i].s);
         check($sformatf("vec%0d_P", i), P, vecs[i].p);
         check($sformatf("vec%0d_G", i), G, vecs[i].g);
         check($sformatf("vec%0d_Cout", i), Cout, vecs[i].cout);
         check($sformatf("vec%0d_OVF", i), OVF, vecs[i].ovf);
      end

      // Random vectors against a 33-bit reference.
      for (int i = 0; i < 10000; i++) begin
         A   = $urandom;
         B   = $urandom;
         Cin = $urandom_range(0, 1) == 1;
         ref_sum = {1'b0, A} + {1'b0, B} + {32'h0, Cin};
         ref_ovf = (A[31] == B[31]) && (ref_sum[31] != A[31]);
         settle();
         check($sformatf("rnd%0d_sum", i), {S, Cout, OVF}, {ref_sum[31:0], ref_sum[32], ref_ovf});
         check($sformatf("rnd%0d_pg", i), {P, G}, {A ^ B, A & B});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_adder_struct
